// File: rtl/ti_share_encoder_if.sv
// Share-encoder handshake bundle: plain input, PRNG input and share output.
// slave is the encoder side, master the producer/consumer side.
interface ti_share_encoder_if #(
  parameter int WIDTH   = 4,
  parameter int NSHARES = 4,
  parameter int CNT_W   = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_data;
  logic                       rnd_valid;
  logic                       rnd_ready;
  logic [(NSHARES-1)*WIDTH-1:0] rnd_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [NSHARES*WIDTH-1:0]   out_shares;
  logic [CNT_W-1:0]           enc_count;

  modport slave (
    input  in_valid, in_data,
    output in_ready,
    input  rnd_valid, rnd_data,
    output rnd_ready,
    output out_valid, out_shares,
    input  out_ready,
    output enc_count
  );

  modport master (
    output in_valid, in_data,
    input  in_ready,
    output rnd_valid, rnd_data,
    input  rnd_ready,
    input  out_valid, out_shares,
    output out_ready,
    input  enc_count
  );
endinterface

// File: rtl/ti_share_encoder.sv
// Boolean masking front end: splits a plain nibble into NSHARES shares
// using one fresh PRNG word per encoding; outputs are all registered.
module ti_share_encoder #(
  parameter int WIDTH   = 4,
  parameter int NSHARES = 4,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic rst,
  ti_share_encoder_if.slave bus
);

  localparam int RW = (NSHARES-1)*WIDTH;
  localparam int SW = NSHARES*WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RND,
    HOLD
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_plain;
  logic [SW-1:0]    r_shares;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_rnd_ready;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_mask;
  logic [SW-1:0]    w_shares;
  logic             w_in_fire;
  logic             w_rnd_fire;
  logic             w_out_fire;

  // Last share absorbs the plain value so the XOR of all shares recovers it.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NSHARES-1; i++) begin
      w_mask = w_mask ^ bus.rnd_data[i*WIDTH +: WIDTH];
    end
    w_shares = {w_mask ^ r_plain, bus.rnd_data};
  end

  assign w_in_fire  = bus.in_valid  && r_in_ready;
  assign w_rnd_fire = bus.rnd_valid && r_rnd_ready;
  assign w_out_fire = bus.out_ready && r_out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_plain     <= '0;
      r_shares    <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_rnd_ready <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_in_fire) begin
            r_plain     <= bus.in_data;
            r_in_ready  <= 1'b0;
            r_rnd_ready <= 1'b1;
            r_state     <= WAIT_RND;
          end else begin
            r_in_ready  <= 1'b1;
          end
        end
        WAIT_RND: begin
          if (w_rnd_fire) begin
            r_shares    <= w_shares;
            r_plain     <= '0;
            r_rnd_ready <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (w_out_fire) begin
            r_shares    <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            if (r_cnt != {CNT_W{1'b1}}) begin
              r_cnt <= r_cnt + 1'b1;
            end
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_plain     <= '0;
          r_shares    <= '0;
          r_in_ready  <= 1'b0;
          r_rnd_ready <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.rnd_ready  = r_rnd_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_shares = r_shares;
  assign bus.enc_count  = r_cnt;

  a_rnd_only_wait: assert property (
    @(posedge clk) disable iff (rst)
    r_rnd_ready |-> (r_state == WAIT_RND)
  );

  a_no_overlap: assert property (
    @(posedge clk) disable iff (rst)
    !(r_in_ready && (r_rnd_ready || r_out_valid))
  );

endmodule

// File: tb/tb_ti_share_encoder.sv
// Directed bench for ti_share_encoder: default instance plus a CNT_W=2
// instance for the saturating counter.
module tb_ti_share_encoder;

  logic clk;
  logic rst;
  int   vec;
  int   errs;

  ti_share_encoder_if #(.WIDTH(4), .NSHARES(4), .CNT_W(16)) bus ();
  ti_share_encoder_if #(.WIDTH(4), .NSHARES(4), .CNT_W(2))  sbus ();

  ti_share_encoder #(.WIDTH(4), .NSHARES(4), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  ti_share_encoder #(.WIDTH(4), .NSHARES(4), .CNT_W(2)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vec++;
    if (bus.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL rst_in_ready got %b want 0", bus.in_ready);
    end
    vec++;
    if (bus.rnd_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_flags got rr=%b ov=%b want 0 0",
               bus.rnd_ready, bus.out_valid);
    end
    vec++;
    if (bus.out_shares !== 16'h0 || bus.enc_count !== 16'h0) begin
      errs++;
      $display("FAIL rst_regs got sh=%h cnt=%0d want 0 0",
               bus.out_shares, bus.enc_count);
    end
    rst = 1'b0;
    tick();
    vec++;
    if (bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL rst_release_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hA;
    tick();
    bus.in_valid = 1'b0;
    vec++;
    if (bus.rnd_ready !== 1'b1 || bus.in_ready !== 1'b0 ||
        bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL basic_wait got rr=%b ir=%b ov=%b want 1 0 0",
               bus.rnd_ready, bus.in_ready, bus.out_valid);
    end
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = 12'h321;
    bus.out_ready = 1'b1;
    tick();
    bus.rnd_valid = 1'b0;
    vec++;
    if (bus.out_valid !== 1'b1 || bus.out_shares !== 16'hA321) begin
      errs++;
      $display("FAIL basic_shares got ov=%b sh=%h want 1 a321",
               bus.out_valid, bus.out_shares);
    end
    tick();
    vec++;
    if (bus.out_valid !== 1'b0 || bus.out_shares !== 16'h0 ||
        bus.enc_count !== 16'd1) begin
      errs++;
      $display("FAIL basic_done got ov=%b sh=%h cnt=%0d want 0 0 1",
               bus.out_valid, bus.out_shares, bus.enc_count);
    end
  endtask

  task automatic test_mask();
    logic [3:0] x;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hA;
    tick();
    bus.in_valid  = 1'b0;
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = 12'h5C7;
    tick();
    bus.rnd_valid = 1'b0;
    vec++;
    if (bus.out_shares !== 16'h45C7) begin
      errs++;
      $display("FAIL mask_shares got %h want 45c7", bus.out_shares);
    end
    x = bus.out_shares[3:0] ^ bus.out_shares[7:4] ^
        bus.out_shares[11:8] ^ bus.out_shares[15:12];
    vec++;
    if (x !== 4'hA) begin
      errs++;
      $display("FAIL mask_recombine got %h want a", x);
    end
    tick();
    vec++;
    if (bus.enc_count !== 16'd2) begin
      errs++;
      $display("FAIL mask_count got %0d want 2", bus.enc_count);
    end
  endtask

  task automatic test_prng_stall();
    int bad;
    bad = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'h3;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.rnd_ready !== 1'b1 || bus.out_valid !== 1'b0) bad++;
      tick();
    end
    vec++;
    if (bad != 0) begin
      errs++;
      $display("FAIL stall_wait got %0d bad cycles want 0", bad);
    end
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = 12'h000;
    tick();
    bus.rnd_valid = 1'b0;
    vec++;
    if (bus.out_valid !== 1'b1 || bus.out_shares !== 16'h3000) begin
      errs++;
      $display("FAIL stall_shares got ov=%b sh=%h want 1 3000",
               bus.out_valid, bus.out_shares);
    end
    tick();
    vec++;
    if (bus.enc_count !== 16'd3) begin
      errs++;
      $display("FAIL stall_count got %0d want 3", bus.enc_count);
    end
  endtask

  task automatic test_back_pressure();
    int bad;
    bad = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h9;
    tick();
    bus.in_valid  = 1'b0;
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = 12'h0F1;
    tick();
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h5;
    bus.rnd_data  = 12'hABC;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_shares !== 16'h70F1 || bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0 || bus.rnd_ready !== 1'b0) bad++;
      tick();
    end
    vec++;
    if (bad != 0 || bus.out_shares !== 16'h70F1) begin
      errs++;
      $display("FAIL bp_hold got %0d bad cycles sh=%h want 0 70f1",
               bad, bus.out_shares);
    end
    bus.out_ready = 1'b1;
    tick();
    vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.enc_count !== 16'd4) begin
      errs++;
      $display("FAIL bp_release got ov=%b ir=%b cnt=%0d want 0 1 4",
               bus.out_valid, bus.in_ready, bus.enc_count);
    end
    tick();
    bus.in_valid = 1'b0;
    vec++;
    if (bus.rnd_ready !== 1'b1 || bus.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL bp_next_accept got rr=%b ir=%b want 1 0",
               bus.rnd_ready, bus.in_ready);
    end
    tick();
    bus.rnd_valid = 1'b0;
    vec++;
    if (bus.out_shares !== 16'h8ABC) begin
      errs++;
      $display("FAIL bp_next_shares got %h want 8abc", bus.out_shares);
    end
    tick();
    vec++;
    if (bus.enc_count !== 16'd5) begin
      errs++;
      $display("FAIL bp_count got %0d want 5", bus.enc_count);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h6;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec++;
    if (bus.out_valid !== 1'b0 || bus.out_shares !== 16'h0 ||
        bus.enc_count !== 16'd0 || bus.rnd_ready !== 1'b0) begin
      errs++;
      $display("FAIL rstwait got ov=%b sh=%h cnt=%0d rr=%b want 0 0 0 0",
               bus.out_valid, bus.out_shares, bus.enc_count, bus.rnd_ready);
    end
    bus.rnd_valid = 1'b1;
    bus.rnd_data  = 12'h123;
    tick();
    tick();
    vec++;
    if (bus.out_valid !== 1'b0 || bus.rnd_ready !== 1'b0 ||
        bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL rstwait_dropped got ov=%b rr=%b ir=%b want 0 0 1",
               bus.out_valid, bus.rnd_ready, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.rnd_valid = 1'b0;
    vec++;
    if (bus.out_valid !== 1'b1 || bus.out_shares !== 16'h6123) begin
      errs++;
      $display("FAIL rsthold_pre got ov=%b sh=%h want 1 6123",
               bus.out_valid, bus.out_shares);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    vec++;
    if (bus.out_valid !== 1'b0 || bus.out_shares !== 16'h0 ||
        bus.enc_count !== 16'd0) begin
      errs++;
      $display("FAIL rsthold got ov=%b sh=%h cnt=%0d want 0 0 0",
               bus.out_valid, bus.out_shares, bus.enc_count);
    end
    tick();
    tick();
    vec++;
    if (bus.out_valid !== 1'b0 || bus.enc_count !== 16'd0) begin
      errs++;
      $display("FAIL rsthold_after got ov=%b cnt=%0d want 0 0",
               bus.out_valid, bus.enc_count);
    end
  endtask

  task automatic test_saturation();
    logic [1:0]  exp_cnt [5];
    logic [15:0] exp_sh;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    sbus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sbus.in_valid = 1'b1;
      sbus.in_data  = 4'(i + 1);
      tick();
      sbus.in_valid  = 1'b0;
      sbus.rnd_valid = 1'b1;
      sbus.rnd_data  = 12'h000;
      tick();
      sbus.rnd_valid = 1'b0;
      exp_sh = {4'(i + 1), 12'h000};
      vec++;
      if (sbus.out_shares !== exp_sh) begin
        errs++;
        $display("FAIL sat_shares[%0d] got %h want %h",
                 i, sbus.out_shares, exp_sh);
      end
      tick();
      vec++;
      if (sbus.enc_count !== exp_cnt[i]) begin
        errs++;
        $display("FAIL sat_count[%0d] got %0d want %0d",
                 i, sbus.enc_count, exp_cnt[i]);
      end
    end
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    rst  = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.rnd_valid  = 1'b0;
    bus.rnd_data   = '0;
    bus.out_ready  = 1'b0;
    sbus.in_valid  = 1'b0;
    sbus.in_data   = '0;
    sbus.rnd_valid = 1'b0;
    sbus.rnd_data  = '0;
    sbus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_mask();
    test_prng_stall();
    test_back_pressure();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
